// File: rtl/systolic_array_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : systolic_array_ctrl_if
// Description : Command and array/buffer control bundle for the systolic
//               array sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface systolic_array_ctrl_if #(
    parameter int N     = 4,
    parameter int LEN_W = 8,
    parameter int IDX_W = 2
);
    logic             start;
    logic             abort;
    logic [LEN_W-1:0] len;
    logic             busy;
    logic             done;
    logic             w_load_en;
    logic [IDX_W-1:0] w_row_sel;
    logic             a_rd_en;
    logic [LEN_W-1:0] a_rd_addr;
    logic [N-1:0]     skew_valid;
    logic             out_valid;
    logic [LEN_W-1:0] out_row_idx;

    modport master (
        output start, abort, len,
        input  busy, done, w_load_en, w_row_sel, a_rd_en, a_rd_addr,
               skew_valid, out_valid, out_row_idx
    );

    modport slave (
        input  start, abort, len,
        output busy, done, w_load_en, w_row_sel, a_rd_en, a_rd_addr,
               skew_valid, out_valid, out_row_idx
    );
endinterface
`default_nettype wire

// File: rtl/systolic_array_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : systolic_array_ctrl
// Description : Sequencer for an N x N weight-stationary systolic array:
//               weight load, skewed activation streaming, result flagging.
// Revision    : 1.0 - initial release
// ============================================================================
module systolic_array_ctrl #(
    parameter int N     = 4,
    parameter int LEN_W = 8,
    parameter int IDX_W = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    systolic_array_ctrl_if.slave bus
);

    localparam logic [2:0] c_idle   = 3'd0;
    localparam logic [2:0] c_load_w = 3'd1;
    localparam logic [2:0] c_stream = 3'd2;
    localparam logic [2:0] c_drain  = 3'd3;
    localparam logic [2:0] c_done   = 3'd4;

    localparam int               c_dly      = 2 * N;
    localparam logic [LEN_W-1:0] c_last_row = LEN_W'(N - 1);
    localparam logic [LEN_W-1:0] c_one      = LEN_W'(1);

    logic [2:0]       r_state;
    logic [2:0]       w_state_nxt;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_cnt;
    logic [LEN_W-1:0] r_ridx;
    logic [c_dly-1:0] r_dly;
    logic             w_accept;
    logic             w_abort;
    logic             w_a_rd_en;
    logic             w_out_valid;
    logic             w_cnt_run;

    assign w_accept    = (r_state == c_idle) && bus.start;
    assign w_abort     = (r_state != c_idle) && bus.abort;
    assign w_a_rd_en   = (r_state == c_stream);
    assign w_out_valid = r_dly[c_dly-1];
    assign w_cnt_run   = (w_state_nxt == r_state) &&
                         ((r_state == c_load_w) || (r_state == c_stream));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_idle: begin
                if (bus.start) begin
                    w_state_nxt = (bus.len != '0) ? c_load_w : c_done;
                end
            end
            c_load_w: begin
                if (r_cnt == c_last_row) begin
                    w_state_nxt = c_stream;
                end
            end
            c_stream: begin
                if (r_cnt == (r_len - c_one)) begin
                    w_state_nxt = c_drain;
                end
            end
            c_drain: begin
                if (w_out_valid && (r_ridx == (r_len - c_one))) begin
                    w_state_nxt = c_done;
                end
            end
            c_done:  w_state_nxt = c_idle;
            default: w_state_nxt = c_idle;
        endcase
        if (w_abort) begin
            w_state_nxt = c_idle;
        end
    end

    // Bit k of r_dly is a_rd_en delayed by k+1 cycles: the low N bits are the
    // per-row skew enables, the top bit marks a result row at the bottom edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_len  <= '0;
            r_cnt  <= '0;
            r_ridx <= '0;
            r_dly  <= '0;
        end else begin
            if (w_accept) begin
                r_len <= bus.len;
            end
            r_cnt <= w_cnt_run ? (r_cnt + c_one) : '0;
            if (w_abort) begin
                r_dly <= '0;
            end else begin
                r_dly <= {r_dly[c_dly-2:0], w_a_rd_en};
            end
            if (w_accept || w_abort) begin
                r_ridx <= '0;
            end else if (w_out_valid) begin
                r_ridx <= r_ridx + c_one;
            end
        end
    end

    always_comb begin
        bus.busy        = (r_state == c_load_w) || (r_state == c_stream) ||
                          (r_state == c_drain);
        bus.done        = (r_state == c_done);
        bus.w_load_en   = (r_state == c_load_w);
        bus.w_row_sel   = (r_state == c_load_w) ? r_cnt[IDX_W-1:0] : '0;
        bus.a_rd_en     = w_a_rd_en;
        bus.a_rd_addr   = w_a_rd_en ? r_cnt : '0;
        bus.skew_valid  = r_dly[N-1:0];
        bus.out_valid   = w_out_valid;
        bus.out_row_idx = w_out_valid ? r_ridx : '0;
    end

endmodule
`default_nettype wire

// File: tb/tb_systolic_array_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_systolic_array_ctrl
// Description : Scoreboard bench for systolic_array_ctrl with directed jobs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_systolic_array_ctrl;

    localparam int N     = 4;
    localparam int LEN_W = 8;
    localparam int IDX_W = 2;
    localparam int NEVER = 32'h3fff_ffff;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    systolic_array_ctrl_if #(.N(N), .LEN_W(LEN_W), .IDX_W(IDX_W)) bus();

    systolic_array_ctrl #(.N(N), .LEN_W(LEN_W), .IDX_W(IDX_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int cyc;
        int val;
    } ev_t;

    // Channels: 0 weight load, 1 activation read, 2 skew mask, 3 result, 4 done
    ev_t q[5][$];
    int  cyc   = 0;
    int  n_cmp = 0;
    int  n_bad = 0;
    int  b_lo  = 1;
    int  b_hi  = 0;
    bit  mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic chk_ev(input int ch, input string nm, input int val);
        ev_t e;
        if (q[ch].size() == 0) begin
            check({nm, "_unexpected_at_cycle"}, cyc, -1);
        end else begin
            e = q[ch].pop_front();
            check({nm, "_cycle"}, cyc, e.cyc);
            if (ch != 4) check({nm, "_value"}, val, e.val);
        end
    endtask

    function automatic void push(input int ch, input int c, input int v, input int cut);
        ev_t e;
        e.cyc = c;
        e.val = v;
        if (c < cut) q[ch].push_back(e);
    endfunction

    function automatic int outvec();
        return int'({bus.busy, bus.done, bus.w_load_en, bus.w_row_sel, bus.a_rd_en,
                     bus.a_rd_addr, bus.skew_valid, bus.out_valid, bus.out_row_idx});
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.w_load_en)          chk_ev(0, "w_load", int'(bus.w_row_sel));
            if (bus.a_rd_en)            chk_ev(1, "a_rd",   int'(bus.a_rd_addr));
            if (bus.skew_valid != '0)   chk_ev(2, "skew",   int'(bus.skew_valid));
            if (bus.out_valid)          chk_ev(3, "out",    int'(bus.out_row_idx));
            if (bus.done)               chk_ev(4, "done",   0);
            check("busy", int'(bus.busy), int'(cyc >= b_lo && cyc <= b_hi));
        end
    end

    task automatic check_drained();
        for (int ch = 0; ch < 5; ch++) begin
            check($sformatf("leftover_ch%0d", ch), q[ch].size(), 0);
            q[ch].delete();
        end
    endtask

    // Start at relative cycle 0; optional ignored restart and abort cycles (-1 = none).
    task automatic job(input int l, input int restart_at, input int abort_at);
        int t0, last, cut, total, mask, m;
        t0   = cyc;
        last = (l == 0) ? t0 + 1 : t0 + 3 * N + l + 1;
        cut  = (abort_at >= 1) ? t0 + abort_at + 1 : NEVER;
        if (l == 0) begin
            push(4, last, 0, cut);
        end else begin
            for (int k = 0; k < N; k++) push(0, t0 + 1 + k, k, cut);
            for (int i = 0; i < l; i++) begin
                push(1, t0 + N + 1 + i, i, cut);
                push(3, t0 + 3 * N + 1 + i, i, cut);
            end
            for (int c = t0 + N + 2; c <= t0 + 2 * N + l; c++) begin
                mask = 0;
                for (int r = 0; r < N; r++) begin
                    m = c - (t0 + N + 1) - (r + 1);
                    if (m >= 0 && m < l) mask |= (1 << r);
                end
                if (mask != 0) push(2, c, mask, cut);
            end
            push(4, last, 0, cut);
        end
        b_lo  = t0 + 1;
        b_hi  = (l == 0) ? t0 : ((cut <= last) ? cut - 1 : last - 1);
        total = ((cut <= last) ? abort_at : last - t0) + 4;
        for (int k = 0; k < total; k++) begin
            bus.start = (k == 0) || (k == restart_at);
            bus.len   = (k == 0) ? LEN_W'(l) : LEN_W'(7);
            bus.abort = (k == abort_at);
            @(posedge clk);
            #1;
        end
        bus.start = 1'b0;
        bus.abort = 1'b0;
        check_drained();
    endtask

    // Asynchronous reset during the first STREAM cycle of a len=3 job.
    task automatic rst_mid();
        int t0;
        t0 = cyc;
        for (int k = 0; k < N; k++) push(0, t0 + 1 + k, k, NEVER);
        push(1, t0 + N + 1, 0, NEVER);
        b_lo = t0 + 1;
        b_hi = t0 + N + 1;
        bus.start = 1'b1;
        bus.len   = LEN_W'(3);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (N) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_outputs", outvec(), 0);
        @(posedge clk);
        #3;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_drained();
    endtask

    initial begin
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.len   = '0;
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b0;
        @(negedge clk);
        check("reset_outputs", outvec(), 0);
        @(posedge clk);
        #1;
        mon_en = 1'b1;

        job(3, -1, -1);
        job(0, -1, -1);
        job(3, 6, -1);
        job(3, -1, 9);
        job(1, -1, -1);
        job(2, -1, 0);
        rst_mid();
        job(2, -1, -1);
        job(255, -1, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
